// File: rtl/serial_subtractor_16bit_if.sv
// Operand/result bundle for the bit-serial subtractor: the controller drives
// start and operands (master); the subtractor returns status and result (slave).
interface serial_subtractor_16bit_if #(
    parameter int unsigned NUM_BITS = 16
);
    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                borrow_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] diff;
    logic                underflow;

    modport master (
        output start,
        output a,
        output b,
        output borrow_in,
        input  busy,
        input  done,
        input  diff,
        input  underflow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  borrow_in,
        output busy,
        output done,
        output diff,
        output underflow
    );
endinterface

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial unsigned subtractor: diff = a - b - borrow_in, one bit per clock, LSB first,
// using a single full-subtractor cell between two operand shift registers.
module serial_subtractor_16bit #(
    parameter int unsigned NUM_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_subtractor_16bit_if.slave  bus
);

    localparam int unsigned CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] sa_q, sa_d;
    logic [NUM_BITS-1:0] sb_q, sb_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                br_q, br_d;
    logic                uf_q, uf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                d_bit;
    logic                br_next;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        diff_d  = diff_q;
        br_d    = br_q;
        uf_d    = uf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.borrow_in;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                diff_d = {d_bit, diff_q[NUM_BITS-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                    uf_d    = br_next;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            uf_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            uf_q    <= uf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status is decoded from state only, so start never reaches busy/done combinationally.
    always_comb begin
        bus.busy      = (state_q == StRun);
        bus.done      = (state_q == StDone);
        bus.diff      = diff_q;
        bus.underflow = uf_q;
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit: directed cases plus a back-to-back
// random run checked against an integer-arithmetic reference.
module tb_serial_subtractor_16bit;

    localparam int unsigned NUM_BITS = 16;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor_16bit_if #(.NUM_BITS(NUM_BITS)) bus ();

    serial_subtractor_16bit #(.NUM_BITS(NUM_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expd);
        end
    endtask

    // Reference: plain signed integer subtraction.
    task automatic ref_sub(input logic [15:0] ra, input logic [15:0] rb, input logic rbin,
                           output logic [15:0] rdiff, output logic ruf);
        int r;
        r     = int'(ra) - int'(rb) - int'(rbin);
        rdiff = 16'(r);
        ruf   = (r < 0);
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after the DONE->IDLE edge.
    task automatic run_dir(input string tag, input logic [15:0] ta, input logic [15:0] tb_b,
                           input logic tbin, input logic [15:0] exp_diff, input logic exp_uf);
        int lat;
        bus.a         = ta;
        bus.b         = tb_b;
        bus.borrow_in = tbin;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.a         = ~ta;
        bus.b         = ~tb_b;
        bus.borrow_in = ~tbin;
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd16);
        check_eq({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check_eq({tag, "_underflow"}, 32'(bus.underflow), 32'(exp_uf));
        check_eq({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ebin;
        logic [15:0] exp_d;
        logic        exp_u;
        int          done_cnt;
        int          relaunch;
        bit          seen_done;
        int          cyc;
        int          prev_done;
        int          n_ops;
        int          wait_cyc;
        bit          idle_check;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(bus.busy), 32'd0);
        check_eq("reset_done", 32'(bus.done), 32'd0);
        check_eq("reset_diff", 32'(bus.diff), 32'd0);
        check_eq("reset_underflow", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_dir("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        run_dir("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_dir("bin_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run_dir("bin_8000", 16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
        // Leave underflow=1 so the asynchronous clear below is observable.
        run_dir("wrap2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

        // Reset in the middle of a run.
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("midrst_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        check_eq("midrst_diff", 32'(bus.diff), 32'd0);
        check_eq("midrst_underflow", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_dir("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

        // start pulsed with new operands during RUN must be ignored.
        bus.a         = 16'h00FF;
        bus.b         = 16'h000F;
        bus.borrow_in = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_cnt  = 0;
        relaunch  = 0;
        seen_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) begin
                bus.start     = 1'b1;
                bus.a         = 16'hAAAA;
                bus.b         = 16'h5555;
                bus.borrow_in = 1'b1;
            end
            if (i == 4) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                seen_done = 1'b1;
                check_eq("ignore_diff", 32'(bus.diff), 32'h00F0);
                check_eq("ignore_underflow", 32'(bus.underflow), 32'd0);
            end else if (seen_done && bus.busy) begin
                relaunch++;
            end
        end
        check_eq("ignore_done_count", 32'(done_cnt), 32'd1);
        check_eq("ignore_relaunch", 32'(relaunch), 32'd0);

        // Back-to-back with start held high; operands change only when they cannot be sampled.
        ea   = 16'($urandom);
        eb   = 16'($urandom);
        ebin = 1'($urandom_range(0, 1));
        ref_sub(ea, eb, ebin, exp_d, exp_u);
        bus.a         = ea;
        bus.b         = eb;
        bus.borrow_in = ebin;
        bus.start     = 1'b1;
        cyc        = 0;
        prev_done  = -1;
        n_ops      = 0;
        wait_cyc   = 0;
        idle_check = 1'b0;
        while (n_ops < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            wait_cyc++;
            if (idle_check) begin
                check_eq("b2b_done_width", 32'(bus.done), 32'd0);
                check_eq("b2b_idle_busy", 32'(bus.busy), 32'd0);
                idle_check = 1'b0;
            end
            if (bus.done) begin
                check_eq("b2b_diff", 32'(bus.diff), 32'(exp_d));
                check_eq("b2b_underflow", 32'(bus.underflow), 32'(exp_u));
                check_eq("b2b_busy_in_done", 32'(bus.busy), 32'd0);
                if (prev_done >= 0) check_eq("b2b_period", 32'(cyc - prev_done), 32'd18);
                prev_done  = cyc;
                n_ops++;
                wait_cyc   = 0;
                idle_check = 1'b1;
                ea   = 16'($urandom);
                eb   = 16'($urandom);
                ebin = 1'($urandom_range(0, 1));
                ref_sub(ea, eb, ebin, exp_d, exp_u);
                bus.a         = ea;
                bus.b         = eb;
                bus.borrow_in = ebin;
            end else if (bus.busy) begin
                bus.a         = 16'($urandom);
                bus.b         = 16'($urandom);
                bus.borrow_in = 1'($urandom_range(0, 1));
            end
            if (wait_cyc > 40) begin
                check_eq("b2b_timeout", 32'(bus.done), 32'd1);
                break;
            end
        end
        bus.start = 1'b0;
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
